// File: rtl/tap_scan_master.sv
// rtl/tap_scan_master.sv - JTAG TAP master: one-cycle commands to TCK/TMS/TDO waveforms with TDI capture
module tap_scan_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_done,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdo,
    output logic               trst_n,
    input  logic               tdi
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RST, S_PRE, S_SHIFT, S_POST, S_DONE
    } state_t;

    state_t             state, first_q, up_state, nxt_state, first_c;
    logic [1:0]         op_q;
    logic [LEN_W-1:0]   len_q, step, up_step, nxt_step, len_c;
    logic [MAX_LEN-1:0] data_q;
    logic [7:0]         div_cnt;
    logic               tck_hi, tap_synced;

    function automatic logic [LEN_W-1:0] last_of(state_t s, logic [1:0] op, logic [LEN_W-1:0] len);
        case (s)
            S_RST:   return LEN_W'(5);
            S_PRE:   return (op == 2'b01) ? LEN_W'(3) : LEN_W'(2);
            S_SHIFT: return len - LEN_W'(1);
            default: return LEN_W'(1);
        endcase
    endfunction

    function automatic logic tms_of(state_t s, logic [LEN_W-1:0] st, logic [1:0] op, logic [LEN_W-1:0] len);
        case (s)
            S_RST:   return st != LEN_W'(5);
            S_PRE:   return (op == 2'b01) ? (st < LEN_W'(2)) : (st == '0);
            S_SHIFT: return (op != 2'b11) && (st == len - LEN_W'(1));
            S_POST:  return st == '0;
            default: return 1'b0;
        endcase
    endfunction

    assign busy = ~cmd_ready;

    always_comb begin
        len_c = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
        if (cmd_op == 2'b00)      first_c = S_RST;
        else if (len_c == '0)     first_c = S_DONE;
        else if (!tap_synced)     first_c = S_RST;
        else if (cmd_op == 2'b11) first_c = S_SHIFT;
        else                      first_c = S_PRE;

        nxt_state = state;
        nxt_step  = step + LEN_W'(1);
        if (step == last_of(state, op_q, len_q)) begin
            nxt_step = '0;
            case (state)
                S_RST:   nxt_state = (op_q == 2'b00) ? S_DONE : (op_q == 2'b11) ? S_SHIFT : S_PRE;
                S_PRE:   nxt_state = S_SHIFT;
                S_SHIFT: nxt_state = (op_q == 2'b11) ? S_DONE : S_POST;
                default: nxt_state = S_DONE;
            endcase
        end

        // The TCK about to start: either the first one of a command or the successor of the current one
        up_state = (state == S_LAUNCH) ? first_q : nxt_state;
        up_step  = (state == S_LAUNCH) ? '0 : nxt_step;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            first_q    <= S_IDLE;
            op_q       <= '0;
            len_q      <= '0;
            data_q     <= '0;
            step       <= '0;
            div_cnt    <= '0;
            tck_hi     <= 1'b0;
            tap_synced <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_done   <= 1'b0;
            rsp_data   <= '0;
            tck        <= 1'b0;
            tms        <= 1'b1;
            tdo        <= 1'b0;
            trst_n     <= 1'b1;
        end else begin
            rsp_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        len_q     <= len_c;
                        data_q    <= cmd_data;
                        rsp_data  <= '0;
                        first_q   <= first_c;
                        state     <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    if (state == S_LAUNCH || (tck_hi && div_cnt == '0)) begin
                        tck     <= 1'b0;
                        tck_hi  <= 1'b0;
                        div_cnt <= DIV_M1;
                        state   <= up_state;
                        step    <= up_step;
                        if (state == S_RST && up_state != S_RST)
                            tap_synced <= 1'b1;
                        if (up_state == S_DONE) begin
                            rsp_done <= 1'b1;
                            // Park in RTI unless a zero-length command ran before any reset sequence
                            tms      <= ~(tap_synced | (state != S_LAUNCH));
                            tdo      <= 1'b0;
                            trst_n   <= 1'b1;
                        end else begin
                            tms    <= tms_of(up_state, up_step, op_q, len_q);
                            tdo    <= (up_state == S_SHIFT && op_q != 2'b11) ? data_q[up_step[IDX_W-1:0]] : 1'b0;
                            trst_n <= !(up_state == S_RST && up_step < LEN_W'(5));
                        end
                    end else if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        tck     <= 1'b1;
                        tck_hi  <= 1'b1;
                        div_cnt <= DIV_M1;
                        if (state == S_SHIFT && op_q != 2'b11)
                            rsp_data[step[IDX_W-1:0]] <= tdi;
                    end
                end
            endcase
        end
    end
endmodule
